// File: rtl/demux1to8_stream_pkg.sv
// demux1to8_stream_pkg: shared constants, slot state encoding and select decode
// for the 1-to-8 registered stream demultiplexer.
package demux1to8_stream_pkg;

  localparam int NOUT = 8;
  localparam int SELW = 3;
  localparam int CNTW = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot decode of a channel select.
  function automatic logic [NOUT-1:0] decodeSel(input logic [SELW-1:0] sel);
    logic [NOUT-1:0] oneHot;
    oneHot      = '0;
    oneHot[sel] = 1'b1;
    return oneHot;
  endfunction

endpackage

// File: rtl/demux1to8_stream_if.sv
// demux1to8_stream_if: input word handshake plus the eight flattened output
// channels. Channel k data lives in out_data[k*WIDTH +: WIDTH].
interface demux1to8_stream_if
  import demux1to8_stream_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [SELW-1:0]       in_sel;
  logic [NOUT-1:0]       out_valid;
  logic [NOUT-1:0]       out_ready;
  logic [NOUT*WIDTH-1:0] out_data;

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux1to8_stream_slot.sv
// demux_slot: one-entry holding register for a single output channel.
// A load while full is a pass-through replacement; the top only loads a full
// slot when it is popped in the same cycle.
module demux_slot
  import demux1to8_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  slot_state_e      r_state;
  slot_state_e      w_nextState;
  logic [WIDTH-1:0] r_data;

  // Slot occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Occupancy update: flush beats load, load beats pop.
  always_comb begin
    w_nextState = r_state;
    if (clr) begin
      w_nextState = SLOT_EMPTY;
    end else if (load) begin
      w_nextState = SLOT_FULL;
    end else if (pop) begin
      w_nextState = SLOT_EMPTY;
    end
  end

  // Held word captures the input only when this slot is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (load && !clr) begin
      r_data <= d;
    end
  end

  assign valid = (r_state == SLOT_FULL);
  assign q     = r_data;

endmodule

// File: rtl/demux1to8_stream.sv
// demux1to8_stream: routes one input word per cycle to one of eight channel
// holding registers and counts accepted words.
module demux1to8_stream
  import demux1to8_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  demux1to8_stream_if.slave     bus,
  output logic [CNTW-1:0]       xfer_cnt
);

  logic [NOUT-1:0] w_selOneHot;
  logic [NOUT-1:0] w_valid;
  logic [NOUT-1:0] w_pop;
  logic [NOUT-1:0] w_load;
  logic            w_selFree;
  logic            w_fireIn;
  logic [CNTW-1:0] r_xferCnt;

  assign w_selOneHot = decodeSel(bus.in_sel);
  assign w_pop       = w_valid & bus.out_ready;

  // The selected slot can take a word if it is empty or draining this cycle.
  // Holding in_ready low during reset keeps producers from seeing a phantom accept.
  assign w_selFree    = ~w_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign bus.in_ready = rst_n & ~clr & w_selFree;
  assign w_fireIn     = bus.in_valid & bus.in_ready;
  assign w_load       = {NOUT{w_fireIn}} & w_selOneHot;

  for (genvar k = 0; k < NOUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .load  (w_load[k]),
      .pop   (w_pop[k]),
      .d     (bus.in_data),
      .valid (w_valid[k]),
      .q     (bus.out_data[k*WIDTH +: WIDTH])
    );
  end

  assign bus.out_valid = w_valid;

  // Accepted-word counter, wraps naturally; flush resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xferCnt <= '0;
    end else if (clr) begin
      r_xferCnt <= '0;
    end else if (w_fireIn) begin
      r_xferCnt <= r_xferCnt + 1'b1;
    end
  end

  assign xfer_cnt = r_xferCnt;

endmodule

// File: tb/tb_demux1to8_stream.sv
// tb_demux1to8_stream: directed scenarios plus randomized traffic, checked
// against a per-channel array model of the demultiplexer.
module tb_demux1to8_stream;
  import demux1to8_stream_pkg::*;

  localparam int WIDTH = 32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic [15:0] xfer_cnt;

  demux1to8_stream_if #(.WIDTH(WIDTH)) bus ();

  demux1to8_stream #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic        mValid [8];
  logic [31:0] mData  [8];
  logic [15:0] mCnt;

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic rstN, input logic v, input logic [2:0] s,
                               input logic [31:0] d, input logic [7:0] rdy, input logic c);
    @(posedge clk);
    #1;
    rst_n         = rstN;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = rdy;
    clr           = c;
    #1;
  endtask

  // Every falling edge: compare DUT against the model, then advance the model
  // by what the coming rising edge must do with the inputs now applied.
  always @(negedge clk) begin : compareProc
    logic [7:0]   expValid;
    logic [255:0] expData;
    logic         expReady;
    logic         fireIn;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        mValid[k] = 1'b0;
        mData[k]  = '0;
      end
      mCnt = '0;
    end
    for (int k = 0; k < 8; k++) begin
      expValid[k]          = mValid[k];
      expData[k*32 +: 32]  = mData[k];
    end
    expReady = rst_n && !clr && (!mValid[bus.in_sel] || bus.out_ready[bus.in_sel]);
    checkOutput("model_out_valid", bus.out_valid, expValid);
    checkOutput("model_out_data", bus.out_data, expData);
    checkOutput("model_xfer_cnt", xfer_cnt, mCnt);
    checkOutput("model_in_ready", bus.in_ready, expReady);
    if (rst_n) begin
      fireIn = bus.in_valid && expReady;
      for (int k = 0; k < 8; k++) begin
        if (clr) begin
          mValid[k] = 1'b0;
        end else if (fireIn && bus.in_sel == 3'(k)) begin
          mValid[k] = 1'b1;
          mData[k]  = bus.in_data;
        end else if (mValid[k] && bus.out_ready[k]) begin
          mValid[k] = 1'b0;
        end
      end
      if (clr) mCnt = '0;
      else if (fireIn) mCnt = mCnt + 16'd1;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;

    // Reset, then fill channels 2 and 5 and reset again mid-stream.
    applyStimulus(0, 1, 3'd2, 32'h0, 8'h00, 0);
    checkOutput("reset_in_ready", bus.in_ready, 0);
    applyStimulus(1, 1, 3'd2, 32'h2222_0002, 8'h00, 0);
    applyStimulus(1, 1, 3'd5, 32'h5555_0005, 8'h00, 0);
    applyStimulus(1, 0, 3'd0, 32'h0, 8'h00, 0);
    checkOutput("prefill_valid", bus.out_valid, 8'h24);
    applyStimulus(0, 1, 3'd2, 32'h0, 8'h00, 0);
    checkOutput("midreset_valid", bus.out_valid, 8'h00);
    checkOutput("midreset_cnt", xfer_cnt, 16'h0);
    checkOutput("midreset_in_ready", bus.in_ready, 0);
    checkOutput("midreset_data", bus.out_data, 256'h0);
    applyStimulus(1, 1, 3'd2, 32'hCAFE_0002, 8'h00, 0);
    checkOutput("postreset_in_ready", bus.in_ready, 1);
    applyStimulus(1, 0, 3'd0, 32'h0, 8'h00, 0);
    checkOutput("postreset_valid", bus.out_valid, 8'h04);
    checkOutput("postreset_data2", bus.out_data[2*32 +: 32], 32'hCAFE_0002);

    // Channel 3 holds a word while blocked; channel 4 still accepts.
    applyStimulus(1, 1, 3'd0, 32'h0, 8'h00, 1);
    checkOutput("clr_in_ready", bus.in_ready, 0);
    applyStimulus(1, 1, 3'd3, 32'hA5A5_A5A5, 8'h00, 0);
    checkOutput("ch3_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 3'd0, 32'h0, 8'h00, 0);
      checkOutput("ch3_hold_valid", bus.out_valid, 8'h08);
      checkOutput("ch3_hold_data", bus.out_data[3*32 +: 32], 32'hA5A5_A5A5);
    end
    applyStimulus(1, 1, 3'd3, 32'h1111_1111, 8'h00, 0);
    checkOutput("ch3_blocked", bus.in_ready, 0);
    applyStimulus(1, 1, 3'd4, 32'h4444_4444, 8'h00, 0);
    checkOutput("ch4_in_ready", bus.in_ready, 1);
    applyStimulus(1, 0, 3'd0, 32'h0, 8'h00, 0);
    checkOutput("ch34_valid", bus.out_valid, 8'h18);
    checkOutput("ch3_kept", bus.out_data[3*32 +: 32], 32'hA5A5_A5A5);
    checkOutput("ch4_data", bus.out_data[4*32 +: 32], 32'h4444_4444);

    // Channel 6 pass-through replacement.
    applyStimulus(1, 0, 3'd0, 32'h0, 8'h00, 1);
    applyStimulus(1, 1, 3'd6, 32'h6666_6666, 8'h00, 0);
    applyStimulus(1, 1, 3'd6, 32'h1234_5678, 8'h40, 0);
    checkOutput("ch6_replace_ready", bus.in_ready, 1);
    checkOutput("ch6_full_before", bus.out_valid[6], 1);
    applyStimulus(1, 0, 3'd0, 32'h0, 8'h00, 0);
    checkOutput("ch6_full_after", bus.out_valid[6], 1);
    checkOutput("ch6_data", bus.out_data[6*32 +: 32], 32'h1234_5678);

    // Stream one word to each channel with all consumers ready.
    applyStimulus(1, 0, 3'd0, 32'h0, 8'hFF, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 3'(i), 32'hB000_0000 + i, 8'hFF, 0);
      checkOutput("stream_in_ready", bus.in_ready, 1);
      if (i > 0) begin
        checkOutput("stream_valid", bus.out_valid, 8'h01 << (i - 1));
        checkOutput("stream_data", bus.out_data[(i-1)*32 +: 32], 32'hB000_0000 + i - 1);
      end
    end
    applyStimulus(1, 0, 3'd0, 32'h0, 8'hFF, 0);
    checkOutput("stream_last_valid", bus.out_valid, 8'h80);
    checkOutput("stream_last_data", bus.out_data[7*32 +: 32], 32'hB000_0007);
    checkOutput("stream_cnt", xfer_cnt, 16'd8);

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)), $urandom, 8'($urandom),
                    ($urandom_range(0, 31) == 0));
    end

    // Counter wrap, then flush with channels full.
    applyStimulus(1, 0, 3'd0, 32'h0, 8'hFF, 1);
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1, 1, 3'($urandom_range(0, 7)), $urandom, 8'hFF, 0);
    end
    applyStimulus(1, 0, 3'd0, 32'h0, 8'hFF, 0);
    checkOutput("cnt_ffff", xfer_cnt, 16'hFFFF);
    applyStimulus(1, 1, 3'd1, 32'h0000_0001, 8'hFF, 0);
    applyStimulus(1, 0, 3'd0, 32'h0, 8'h00, 0);
    checkOutput("cnt_wrap", xfer_cnt, 16'h0000);
    applyStimulus(1, 1, 3'd1, 32'h0101_0101, 8'h00, 0);
    applyStimulus(1, 1, 3'd2, 32'h0202_0202, 8'h00, 0);
    applyStimulus(1, 1, 3'd0, 32'h0303_0303, 8'h00, 1);
    checkOutput("flush_in_ready", bus.in_ready, 0);
    checkOutput("flush_prior_valid", bus.out_valid, 8'h06);
    applyStimulus(1, 0, 3'd0, 32'h0, 8'h00, 0);
    checkOutput("flush_valid", bus.out_valid, 8'h00);
    checkOutput("flush_cnt", xfer_cnt, 16'h0);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
